keypad_scan_io: RTL

//  Input-side memory-mapped I/O for the single-cycle computer; the counterpart of the 7-segment display output path.

---
 rtl/keypad_scan_io_if.sv | 10 +
 rtl/keypad_scan_io.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_io_if.sv
// rtl/keypad_scan_io_if.sv - CPU read port and interrupt of the keypad scanner
interface keypad_scan_io_if;
  logic        io_rd;
  logic        io_addr;
  logic [31:0] io_rdata;
  logic        key_irq;

  modport master (output io_rd, output io_addr, input io_rdata, input key_irq);
  modport slave  (input io_rd, input io_addr, output io_rdata, output key_irq);
endinterface

// File: rtl/keypad_scan_io.sv
// rtl/keypad_scan_io.sv - 4x4 keypad scanner with debounce and a key-code FIFO
// read by the CPU as a DATA/STATUS word pair.
module keypad_scan_io #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       ROW_IN,
  output logic [3:0]       COL_OUT,
  keypad_scan_io_if.slave  bus
);

  localparam int            SW        = $clog2(SCAN_DIV);
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N     = 4'(DEBOUNCE_SCANS);
  localparam logic [2:0]    DEPTH_N   = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB,
    ST_HELD
  } state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [SW-1:0] slot_q;
  logic [1:0]    col_q;
  logic [15:0]   snap_q;
  logic [15:0]   snap_d;
  logic          scan_done_q;
  logic          slot_end;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= ROW_IN;
      row_sync <= row_meta;
    end
  end

  assign slot_end = (slot_q == SLOT_LAST);
  assign COL_OUT  = ~(4'b0001 << col_q);

  // Snapshot bit index equals the key code {row, col}; a low row means pressed.
  always_comb begin
    snap_d = snap_q;
    for (int r = 0; r < 4; r++) begin
      snap_d[{2'(r), col_q}] = ~row_sync[r];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      slot_q      <= '0;
      col_q       <= 2'd0;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= slot_end && (col_q == 2'd3);
      if (slot_end) begin
        slot_q <= '0;
        col_q  <= col_q + 2'd1;
        snap_q <= snap_d;
      end else begin
        slot_q <= slot_q + SW'(1);
      end
    end
  end

  logic [4:0] key_n;
  logic [3:0] key_code;
  logic       is_one;
  logic       is_none;

  always_comb begin
    key_n    = '0;
    key_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        key_n    = key_n + 5'd1;
        key_code = 4'(i);
      end
    end
  end

  assign is_one  = (key_n == 5'd1);
  assign is_none = (key_n == 5'd0);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cand_q;
  logic [3:0] cand_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       push;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // In HELD, cnt counts consecutive empty scans toward release.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (scan_done_q) begin
      case (state_q)
        ST_IDLE: begin
          if (is_one) begin
            cand_d = key_code;
            if (DEB_N == 4'd1) begin
              push    = 1'b1;
              state_d = ST_HELD;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_DEB;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_DEB: begin
          if (is_one && (key_code == cand_q)) begin
            if (cnt_q + 4'd1 == DEB_N) begin
              push    = 1'b1;
              state_d = ST_HELD;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (is_one) begin
            cand_d = key_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_HELD: begin
          if (is_none) begin
            if (cnt_q + 4'd1 == DEB_N) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [2:0]    count_q;
  logic          ovf_q;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          rd_stat;
  logic [3:0]    head_code;

  assign empty   = (count_q == 3'd0);
  assign full    = (count_q == DEPTH_N);
  assign pop     = bus.io_rd && !bus.io_addr && !empty;
  assign rd_stat = bus.io_rd && bus.io_addr;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_q] <= key_code;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (rd_stat) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign head_code = empty ? 4'd0 : mem_q[rd_q];

  always_comb begin
    bus.io_rdata = '0;
    if (bus.io_rd) begin
      if (bus.io_addr) begin
        bus.io_rdata = {27'b0, ovf_q, full, count_q};
      end else begin
        bus.io_rdata = {23'b0, ~empty, 4'b0, head_code};
      end
    end
  end

  assign bus.key_irq = ~empty;

endmodule
